letc_core_fetch: RTL
====================

// Module: letc_core_fetch
// PURPOSE
// - Instruction-fetch stage of the LETC core; sits directly upstream of decode.
// - Generates sequential PCs and issues word requests to the instruction-memory port.
// - Buffers in-order responses in a small FIFO of {pc, instr} entries for decode.
// - Accepts redirects (branch/jump/trap) and discards stale in-flight responses.
// PARAMETERS
// - RESET_PC    32'h0000_0000  first fetch address after reset
// - FIFO_DEPTH  2              buffer entries; also the max in-flight + buffered words (>=1)
// PORTS
// - i_clk             in   1   core clock
// - i_rst             in   1   asynchronous reset, active-high
// - o_imem_req_valid  out  1   fetch request valid
// - i_imem_req_ready  in   1   memory accepts the request this cycle
// - o_imem_req_addr   out  32  word-aligned fetch address (core_pkg::word_t)
// - i_imem_rsp_valid  in   1   response valid; in order, >=1 cycle after acceptance
// - i_imem_rsp_data   in   32  fetched instruction word
// - i_redirect_valid  in   1   redirect fetch this cycle
// - i_redirect_pc     in   32  redirect target
// - o_valid           out  1   FIFO head valid to decode
// - i_ready           in   1   decode consumes the head this cycle
// - o_pc              out  32  PC of the head entry
// - o_instr           out  32  instruction of the head entry
// - o_misaligned      out  1   head is a misaligned-fetch marker (see CONFIGURATION)
// BEHAVIOUR
// - State: fetch_pc, rsp_pc, inflight count, discard count, FIFO of FIFO_DEPTH entries.
// - Reset (async): fetch_pc=rsp_pc=RESET_PC; counts=0; FIFO empty.
//   - Outputs during reset: o_imem_req_valid=0, o_valid=0, o_misaligned=0.
// - Credit rule: o_imem_req_valid = (inflight + fifo_count < FIFO_DEPTH) && !i_redirect_valid && !halted.
//   - o_imem_req_addr = fetch_pc.
//   - First request is possible in the first cycle after reset deasserts.
// - Request accept (valid && ready): fetch_pc += 4 (wraps modulo 2^32); inflight++.
// - Response (i_imem_rsp_valid): inflight--.
//   - If discard > 0: drop the word, discard--.
//   - Otherwise push {rsp_pc, data, 0} and rsp_pc += 4.
//   - Overflow is impossible by the credit rule; an overflow is a bench assertion failure.
// - Decode handshake: o_valid = !fifo_empty; pop on o_valid && i_ready.
//   - Head outputs come from registers and are stable while o_valid && !i_ready.
//   - Push and pop in the same cycle are allowed at any occupancy, including full.
//   - A word pushed in cycle N is visible in cycle N+1 (no bypass), so the minimum latency from request acceptance to o_valid is 2 cycles.
// - Redirect in cycle N:
//   - FIFO flushed; any pop in cycle N is ignored.
//   - fetch_pc = rsp_pc = i_redirect_pc; halted cleared.
//   - discard = inflight after this cycle's response, not counting a response arriving in cycle N (that one is dropped).
//   - The cycle N response does not push.
//   - No request is issued in cycle N; a request for the target may issue in N+1.
// - Redirect has priority over every other event in the same cycle.
// - Discarded words still hold credits until they arrive.
// CONFIGURATION
// - Macro LETC_FETCH_MISALIGN_CHECK_EN.
// - Defined: a redirect with i_redirect_pc[1:0] != 0 sets halted, and no requests are issued.
//   - Once discard reaches 0, one entry {pc=target, instr=0, misaligned=1} is pushed.
//   - Fetch then stays idle until the next redirect.
// - Undefined: i_redirect_pc[1:0] is forced to 2'b00; o_misaligned is tied 0; no halted state.
// TESTING
// - Reset, ready=1, memory 1-cycle latency, decode ready:
//   -> requests 0x0, 0x4, 0x8...; o_pc 0x0 with o_instr = word@0x0 two cycles after the first accept.
// - i_ready=0 for 10 cycles:
//   -> FIFO fills to FIFO_DEPTH; o_imem_req_valid drops; head holds pc 0x0.
//   -> on release, entries drain in order with no loss or duplication.
// - Two requests in flight, redirect to 0x100:
//   -> both old responses dropped; next o_pc = 0x100; no stale pc 0x4/0x8 ever seen.
// - Redirect in the same cycle as a response and a decode pop:
//   -> FIFO empty next cycle; that response is discarded; request 0x200 issues next cycle.
// - imem_req_ready low for 5 cycles:
//   -> o_imem_req_addr held constant; fetch_pc advances only on accept.
// - With LETC_FETCH_MISALIGN_CHECK_EN, redirect to 0x102:
//   -> no request issues; one entry with o_pc=0x102, o_misaligned=1; then idle until the next redirect.

Source files
------------

// File: rtl/letc_core_fetch.sv
`default_nettype none
// ============================================================================
// Module   : letc_core_fetch
// Purpose  : Instruction-fetch stage of the LETC core. Issues sequential
//            word requests to the instruction memory, buffers in-order
//            responses as {pc, instr} entries for decode, and handles
//            redirects by flushing the buffer and discarding stale
//            in-flight responses.
// Ports    : i_clk/i_rst        clock, asynchronous active-high reset
//            o_imem_req_*       request channel (valid/ready/addr)
//            i_imem_rsp_*       in-order response channel (valid/data)
//            i_redirect_*       fetch redirect (branch/jump/trap)
//            o_valid/i_ready    head handshake towards decode
//            o_pc/o_instr       head entry contents
//            o_misaligned       head entry is a misaligned-fetch marker
// Options  : `define LETC_FETCH_MISALIGN_CHECK_EN to halt fetch on a
//            misaligned redirect target and emit a marker entry; otherwise
//            the low two target bits are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module letc_core_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_misaligned
);

    localparam int unsigned c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(FIFO_DEPTH - 1);

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        rsp_pc_q, rsp_pc_d;
    logic [c_cnt_w-1:0] inflight_q, inflight_d;
    logic [c_cnt_w-1:0] discard_q, discard_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]        pc_mem_q    [FIFO_DEPTH];
    logic [31:0]        instr_mem_q [FIFO_DEPTH];

    logic [31:0]        w_redir_pc;
    logic               w_halted;
    logic               w_mark_push;
    logic [c_cnt_w:0]   w_used;
    logic               w_credit;
    logic               w_accept;
    logic               w_rsp_push;
    logic               w_push;
    logic               w_pop;

    // Words in flight plus words buffered never exceed the buffer depth, so
    // every response is guaranteed a slot when it arrives.
    assign w_used   = {1'b0, inflight_q} + {1'b0, count_q};
    assign w_credit = w_used < {1'b0, c_depth};

    // Reset gating keeps the request invisible while reset is held.
    assign o_imem_req_valid = !i_rst && w_credit && !i_redirect_valid && !w_halted;
    assign o_imem_req_addr  = fetch_pc_q;
    assign w_accept         = o_imem_req_valid && i_imem_req_ready;

    assign w_rsp_push = i_imem_rsp_valid && (discard_q == '0) && !i_redirect_valid;
    assign w_push     = w_rsp_push || w_mark_push;
    assign w_pop      = o_valid && i_ready && !i_redirect_valid;

    assign o_valid = (count_q != '0);
    assign o_pc    = pc_mem_q[rd_ptr_q];
    assign o_instr = instr_mem_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + c_cnt_w'(w_accept) - c_cnt_w'(i_imem_rsp_valid);
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (i_redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the
            // old path; no request is accepted in a redirect cycle.
            fetch_pc_d = w_redir_pc;
            rsp_pc_d   = w_redir_pc;
            discard_d  = inflight_q - c_cnt_w'(i_imem_rsp_valid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (w_accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (i_imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - c_cnt_w'(1);
            end
            if (w_rsp_push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (w_push) begin
                wr_ptr_d = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + c_ptr_w'(1);
            end
            count_d = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Buffer storage carries no reset; o_valid qualifies it.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
            instr_mem_q[wr_ptr_q] <= w_mark_push ? 32'd0 : i_imem_rsp_data;
        end
    end

`ifdef LETC_FETCH_MISALIGN_CHECK_EN
    logic w_redir_mis;
    logic halted_q, halted_d;
    logic mark_pend_q, mark_pend_d;
    logic mis_mem_q [FIFO_DEPTH];

    assign w_redir_pc  = i_redirect_pc;
    assign w_redir_mis = |i_redirect_pc[1:0];
    assign w_halted    = halted_q;
    // While halted no requests issue, so discard reaching zero means the
    // old path has fully drained and the buffer is empty.
    assign w_mark_push = mark_pend_q && (discard_q == '0) && !i_redirect_valid;

    always_comb begin
        halted_d    = halted_q;
        mark_pend_d = mark_pend_q;
        if (i_redirect_valid) begin
            halted_d    = w_redir_mis;
            mark_pend_d = w_redir_mis;
        end else if (w_mark_push) begin
            mark_pend_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            halted_q    <= 1'b0;
            mark_pend_q <= 1'b0;
        end else begin
            halted_q    <= halted_d;
            mark_pend_q <= mark_pend_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mis_mem_q[wr_ptr_q] <= w_mark_push;
        end
    end

    assign o_misaligned = o_valid && mis_mem_q[rd_ptr_q];
`else
    logic w_unused;

    assign w_redir_pc   = {i_redirect_pc[31:2], 2'b00};
    assign w_unused     = ^i_redirect_pc[1:0];
    assign w_halted     = 1'b0;
    assign w_mark_push  = 1'b0;
    assign o_misaligned = 1'b0;
`endif

endmodule
`default_nettype wire
